// File: rtl/ysyx_22050133_hazard_ctrl_pkg.sv
// Shared types and helpers for the pipeline hazard sequencer.
// Optional perf counters are enabled with HAZARD_CTRL_PERF_EN.
package ysyx_22050133_hazard_ctrl_pkg;

  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned BUB_CNT_W = 3;

  // Sequencer states
  typedef enum logic [1:0] {
    HC_RUN   = 2'd0,
    HC_MEMW  = 2'd1,
    HC_MDW   = 2'd2,
    HC_FLUSH = 2'd3
  } hc_state_e;

  // Per-cycle perf events; bit order matches the perf_cnt slices (loaduse lowest)
  typedef struct packed {
    logic flush;
    logic mdwait;
    logic memwait;
    logic loaduse;
  } hc_perf_ev_t;

  // Decode operand depends on a load still in EX
  function automatic logic hc_load_use(input logic                 id_valid,
                                       input logic                 ex_memread,
                                       input logic [REG_IDX_W-1:0] ex_rd,
                                       input logic [REG_IDX_W-1:0] id_rs1,
                                       input logic [REG_IDX_W-1:0] id_rs2);
    return id_valid && ex_memread && (ex_rd != '0) &&
           ((ex_rd == id_rs1) || (ex_rd == id_rs2));
  endfunction

endpackage

// File: rtl/ysyx_22050133_hazard_perf.sv
// Wrapping event counter bank for the hazard sequencer.
// Compiled only when HAZARD_CTRL_PERF_EN is defined.
`ifdef HAZARD_CTRL_PERF_EN
module ysyx_22050133_hazard_perf
  import ysyx_22050133_hazard_ctrl_pkg::*;
#(
  parameter int unsigned PERF_W = 32
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  hc_perf_ev_t                             ev_i,
  output logic [$bits(hc_perf_ev_t)*PERF_W-1:0]   perf_cnt_o
);

  localparam int unsigned N_EV = $bits(hc_perf_ev_t);

  logic [N_EV-1:0]        ev_vec;
  logic [N_EV*PERF_W-1:0] cnt_q, cnt_d;

  assign ev_vec = ev_i;

  // Each counter adds its event bit and wraps naturally
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < int'(N_EV); i++) begin
      cnt_d[i*PERF_W +: PERF_W] = cnt_q[i*PERF_W +: PERF_W] + PERF_W'(ev_vec[i]);
    end
  end

  // Counter storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign perf_cnt_o = cnt_q;

endmodule
`endif

// File: rtl/ysyx_22050133_hazard_ctrl.sv
// Pipeline sequencer: load-use bubbles, LSU / mul-div holds, redirect flushes.
// Define HAZARD_CTRL_PERF_EN to build the event counters; otherwise perf_cnt is 0.
// Stall outputs assert from the cycle a multi-cycle op is first seen, so the
// pipe never advances past an outstanding LSU access or mul/div op.
module ysyx_22050133_hazard_ctrl
  import ysyx_22050133_hazard_ctrl_pkg::*;
#(
  parameter int unsigned REDIRECT_BUBBLES = 2,
  parameter int unsigned PERF_W           = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_valid,
  input  logic [REG_IDX_W-1:0]   id_rs1,
  input  logic [REG_IDX_W-1:0]   id_rs2,
  input  logic [REG_IDX_W-1:0]   ex_rd,
  input  logic                   ex_memread,
  input  logic                   ex_redirect,
  input  logic                   lsu_busy,
  input  logic                   lsu_done,
  input  logic                   md_start,
  input  logic                   md_done,
  output logic                   has_hazard,
  output logic                   stall_ifid,
  output logic                   stall_idex,
  output logic                   stall_exmem,
  output logic                   bubble_exmem,
  output logic                   flush_ifid,
  output logic                   flush_idex,
  output logic [4*PERF_W-1:0]    perf_cnt
);

  localparam logic [BUB_CNT_W-1:0] BUB_RELOAD = BUB_CNT_W'(REDIRECT_BUBBLES - 1);

  hc_state_e            state_q, state_d;
  logic [BUB_CNT_W-1:0] cnt_q, cnt_d;
  logic                 pend_q, pend_d;
  logic                 load_use;

  assign load_use = hc_load_use(id_valid, ex_memread, ex_rd, id_rs1, id_rs2);

  // State, bubble counter and deferred-redirect flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= HC_RUN;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  // Next state and pipeline controls; everything held low while in reset
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pend_d       = pend_q;
    has_hazard   = 1'b0;
    stall_ifid   = 1'b0;
    stall_idex   = 1'b0;
    stall_exmem  = 1'b0;
    bubble_exmem = 1'b0;
    flush_ifid   = 1'b0;
    flush_idex   = 1'b0;
    if (rst) begin
      case (state_q)
        HC_RUN: begin
          if (ex_redirect) begin
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
            state_d    = HC_FLUSH;
            cnt_d      = BUB_RELOAD;
          end else if (lsu_busy) begin
            stall_ifid  = 1'b1;
            stall_idex  = 1'b1;
            stall_exmem = 1'b1;
            state_d     = HC_MEMW;
          end else if (md_start && !md_done) begin
            stall_ifid   = 1'b1;
            stall_idex   = 1'b1;
            bubble_exmem = 1'b1;
            state_d      = HC_MDW;
          end else if (load_use) begin
            has_hazard = 1'b1;
            stall_ifid = 1'b1;
          end
        end
        HC_MEMW: begin
          stall_ifid  = 1'b1;
          stall_idex  = 1'b1;
          stall_exmem = 1'b1;
          if (ex_redirect) pend_d = 1'b1;
          if (lsu_done) begin
            if (pend_q || ex_redirect) begin
              flush_ifid = 1'b1;
              flush_idex = 1'b1;
              state_d    = HC_FLUSH;
              cnt_d      = BUB_RELOAD;
              pend_d     = 1'b0;
            end else begin
              state_d = HC_RUN;
            end
          end
        end
        HC_MDW: begin
          if (ex_redirect) begin
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
            state_d    = HC_FLUSH;
            cnt_d      = BUB_RELOAD;
          end else if (md_done) begin
            state_d = HC_RUN;
          end else begin
            stall_ifid   = 1'b1;
            stall_idex   = 1'b1;
            bubble_exmem = 1'b1;
          end
        end
        HC_FLUSH: begin
          has_hazard = 1'b1;
          if (ex_redirect) begin
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
            cnt_d      = BUB_RELOAD;
          end else if (cnt_q == '0) begin
            state_d = HC_RUN;
          end else begin
            cnt_d = cnt_q - BUB_CNT_W'(1);
          end
        end
        default: state_d = HC_RUN;
      endcase
    end
  end

`ifdef HAZARD_CTRL_PERF_EN
  hc_perf_ev_t perf_ev;

  // Events derived from the controls actually driven this cycle
  always_comb begin
    perf_ev.loaduse = has_hazard && (state_q == HC_RUN);
    perf_ev.memwait = stall_exmem;
    perf_ev.mdwait  = bubble_exmem;
    perf_ev.flush   = flush_idex;
  end

  ysyx_22050133_hazard_perf #(
    .PERF_W (PERF_W)
  ) u_perf (
    .clk        (clk),
    .rst_n      (rst),
    .ev_i       (perf_ev),
    .perf_cnt_o (perf_cnt)
  );
`else
  assign perf_cnt = '0;
`endif

endmodule

// File: tb/tb_ysyx_22050133_hazard_ctrl.sv
// Self-checking bench for ysyx_22050133_hazard_ctrl (honours HAZARD_CTRL_PERF_EN).
module tb_ysyx_22050133_hazard_ctrl;

  localparam int unsigned RB = 2;
  localparam int unsigned PW = 8;

  logic          clk, rst;
  logic          id_valid, ex_memread, ex_redirect, lsu_busy, lsu_done, md_start, md_done;
  logic [4:0]    id_rs1, id_rs2, ex_rd;
  logic          has_hazard, stall_ifid, stall_idex, stall_exmem, bubble_exmem;
  logic          flush_ifid, flush_idex;
  logic [4*PW-1:0] perf_cnt;

  int unsigned passed = 0, total = 0, fails = 0;

  // Reference model: wait flags, remaining bubble cycles, event totals
  bit            m_mem, m_md, m_pend, n_mem, n_md, n_pend;
  int            m_bub, n_bub;
  logic [PW-1:0] c_lu, c_mem, c_md, c_fl, n_lu, n_memc, n_mdc, n_fl;
  logic [6:0]    exp_o;
  logic [4*PW-1:0] exp_perf;

  ysyx_22050133_hazard_ctrl #(.REDIRECT_BUBBLES(RB), .PERF_W(PW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_redirect(ex_redirect),
    .lsu_busy(lsu_busy), .lsu_done(lsu_done), .md_start(md_start), .md_done(md_done),
    .has_hazard(has_hazard), .stall_ifid(stall_ifid), .stall_idex(stall_idex),
    .stall_exmem(stall_exmem), .bubble_exmem(bubble_exmem), .flush_ifid(flush_ifid),
    .flush_idex(flush_idex), .perf_cnt(perf_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] outs();
    return {has_hazard, stall_ifid, stall_idex, stall_exmem, bubble_exmem, flush_ifid, flush_idex};
  endfunction

  task automatic model_reset();
    m_mem = 0; m_md = 0; m_pend = 0; m_bub = 0;
    c_lu = '0; c_mem = '0; c_md = '0; c_fl = '0;
  endtask

  // Expected controls for the current inputs plus the model's next state
  task automatic model_eval();
    bit hh, si, sx, sm, bx, fi, fx, lu, redir_flush;
    hh = 0; si = 0; sx = 0; sm = 0; bx = 0; fi = 0; fx = 0; redir_flush = 0;
    n_mem = m_mem; n_md = m_md; n_pend = m_pend; n_bub = m_bub;
    n_lu = c_lu; n_memc = c_mem; n_mdc = c_md; n_fl = c_fl;
    lu = id_valid && ex_memread && (ex_rd != 0) && (ex_rd == id_rs1 || ex_rd == id_rs2);
    if (rst) begin
      if (m_bub > 0) begin
        hh = 1;
        if (ex_redirect) redir_flush = 1;
        else n_bub = m_bub - 1;
      end else if (m_mem) begin
        si = 1; sx = 1; sm = 1; n_memc = c_mem + 1'b1;
        if (ex_redirect) n_pend = 1;
        if (lsu_done) begin
          n_mem = 0;
          if (m_pend || ex_redirect) begin redir_flush = 1; n_pend = 0; end
        end
      end else if (m_md) begin
        if (ex_redirect) begin redir_flush = 1; n_md = 0; end
        else if (md_done) n_md = 0;
        else begin si = 1; sx = 1; bx = 1; n_mdc = c_md + 1'b1; end
      end else begin
        if (ex_redirect) redir_flush = 1;
        else if (lsu_busy) begin si = 1; sx = 1; sm = 1; n_memc = c_mem + 1'b1; n_mem = 1; end
        else if (md_start && !md_done) begin si = 1; sx = 1; bx = 1; n_mdc = c_md + 1'b1; n_md = 1; end
        else if (lu) begin hh = 1; si = 1; n_lu = c_lu + 1'b1; end
      end
      if (redir_flush) begin fi = 1; fx = 1; n_bub = RB; n_fl = c_fl + 1'b1; end
    end
    exp_o = {hh, si, sx, sm, bx, fi, fx};
`ifdef HAZARD_CTRL_PERF_EN
    exp_perf = {c_fl, c_md, c_mem, c_lu};
`else
    exp_perf = '0;
`endif
  endtask

  task automatic model_commit();
    m_mem = n_mem; m_md = n_md; m_pend = n_pend; m_bub = n_bub;
    c_lu = n_lu; c_mem = n_memc; c_md = n_mdc; c_fl = n_fl;
  endtask

  // Mid-cycle compare against the model (called at posedge+1)
  task automatic half(input string tag);
    #3;
    model_eval();
    check(tag, 64'(outs()), 64'(exp_o));
    check({tag, "_perf"}, 64'(perf_cnt), 64'(exp_perf));
  endtask

  task automatic tick();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; ex_rd = 0; ex_memread = 0; ex_redirect = 0;
    lsu_busy = 0; lsu_done = 0; md_start = 0; md_done = 0;
  endtask

  task automatic rand_inputs();
    id_valid    = 1'($urandom_range(0, 1));
    id_rs1      = 5'($urandom_range(0, 7));
    id_rs2      = 5'($urandom_range(0, 7));
    ex_rd       = 5'($urandom_range(0, 7));
    ex_memread  = 1'($urandom_range(0, 1));
    ex_redirect = ($urandom_range(0, 15) == 0);
    lsu_busy    = m_mem ? 1'b1 : ($urandom_range(0, 9) == 0);
    lsu_done    = m_mem ? ($urandom_range(0, 3) == 0) : 1'b0;
    md_start    = ($urandom_range(0, 9) == 0);
    md_done     = m_md ? ($urandom_range(0, 5) == 0) : (md_start ? 1'($urandom_range(0, 1)) : 1'b0);
  endtask

  initial begin
    int st_cnt, bx_cnt;
    logic [PW-1:0] mem0, fl0;
    idle();
    rst = 1'b0;
    model_reset();
    #2;
    check("reset_out", 64'(outs()), 64'd0);
    check("reset_perf", 64'(perf_cnt), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Load-use: ld x5 in EX, rs2=5 in decode
    id_valid = 1; id_rs1 = 3; id_rs2 = 5; ex_rd = 5; ex_memread = 1;
    half("lu_hit");
    check("lu_hh", 64'(has_hazard), 64'd1);
    check("lu_stall", 64'(stall_ifid), 64'd1);
    tick();
    ex_memread = 0;
    half("lu_clear");
    check("lu_clear_hh", 64'(has_hazard), 64'd0);
    tick();
    ex_memread = 1; ex_rd = 0; id_rs1 = 0;
    half("lu_x0");
    check("lu_x0_stall", 64'(stall_ifid), 64'd0);
    tick();

    // Redirect in RUN: flush then RB bubble cycles
    idle();
    ex_redirect = 1;
    half("redir0");
    check("redir0_flush", 64'({flush_ifid, flush_idex}), 64'd3);
    tick();
    ex_redirect = 0;
    for (int k = 1; k <= 3; k++) begin
      half("redir_bub");
      check("redir_bub_hh", 64'(has_hazard), (k <= int'(RB)) ? 64'd1 : 64'd0);
      tick();
    end

    // LSU wait of 5 cycles with a redirect deferred until completion
    mem0 = perf_cnt[2*PW-1:PW];
    fl0  = perf_cnt[4*PW-1:3*PW];
    for (int k = 0; k < 5; k++) begin
      lsu_busy = 1; ex_redirect = (k == 2); lsu_done = (k == 4);
      half("memw");
      check("memw_flush", 64'(flush_idex), (k == 4) ? 64'd1 : 64'd0);
      check("memw_stall", 64'(stall_exmem), 64'd1);
      tick();
    end
    idle();
    half("memw_after");
    check("memw_after_hh", 64'(has_hazard), 64'd1);
    tick();
    for (int k = 0; k < 3; k++) begin half("memw_drain"); tick(); end
`ifdef HAZARD_CTRL_PERF_EN
    check("perf_memwait_delta", 64'(PW'(perf_cnt[2*PW-1:PW] - mem0)), 64'd5);
    check("perf_flush_delta", 64'(PW'(perf_cnt[4*PW-1:3*PW] - fl0)), 64'd1);
`else
    check("perf_tied", 64'({mem0, fl0}), 64'd0);
`endif

    // Mul/div: done 33 cycles after start
    st_cnt = 0; bx_cnt = 0;
    for (int k = 0; k <= 33; k++) begin
      md_start = (k == 0); md_done = (k == 33);
      half("mdw");
      st_cnt += int'(stall_idex);
      bx_cnt += int'(bubble_exmem);
      tick();
    end
    check("md_stall_cycles", 64'(st_cnt), 64'd33);
    check("md_bubble_cycles", 64'(bx_cnt), 64'd33);
    md_start = 1; md_done = 1;
    half("md_fast");
    check("md_fast_stall", 64'({stall_idex, bubble_exmem}), 64'd0);
    tick();
    md_done = 0;
    half("md_redir_a");
    tick();
    md_start = 0; ex_redirect = 1;
    half("md_redir_b");
    check("md_redir_flush", 64'({flush_idex, stall_idex}), 64'd2);
    tick();
    idle();
    for (int k = 0; k < 3; k++) begin half("md_redir_drain"); tick(); end

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      rand_inputs();
      half("rand");
      tick();
    end

    // Asynchronous reset in the middle of an LSU wait
    idle();
    for (int k = 0; k < 20 && !(m_mem == 0 && m_md == 0 && m_bub == 0); k++) begin
      half("settle");
      tick();
    end
    lsu_busy = 1;
    half("mrst_a");
    tick();
    half("mrst_b");
    check("mrst_in_memw", 64'(stall_exmem), 64'd1);
    #1;
    rst = 1'b0;
    ex_redirect = 1; id_valid = 1; id_rs1 = 7; ex_rd = 7; ex_memread = 1;
    #1;
    check("mrst_outs", 64'(outs()), 64'd0);
    check("mrst_perf", 64'(perf_cnt), 64'd0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    idle();
    id_valid = 1; id_rs1 = 7; ex_rd = 7; ex_memread = 1;
    half("mrst_run");
    check("mrst_run_hh", 64'({has_hazard, stall_exmem}), 64'd2);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
